// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the alu_seq_ctrl sequencer and the alu_8
// datapath it drives.
//   alu_op_e     : alu_8 opcode encoding (values 5..15 are not defined ops)
//   seq_state_e  : sequencer states IDLE -> LO -> (HI -> (CARRY)) -> IDLE
//   ALU_DATA_W   : width of one alu_8 pass
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    typedef enum logic [3:0] {
        ADD = 4'h0,
        SUB = 4'h1,
        AND = 4'h2,
        OR  = 4'h3,
        XOR = 4'h4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        CARRY
    } seq_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= XOR;
    endfunction

    function automatic logic is_add_sub(input logic [3:0] op);
        return (op == ADD) || (op == SUB);
    endfunction

    // Carry/borrow out of one 8-bit pass, recovered from the pass operands
    // and result because alu_8 has no carry output.
    function automatic logic carry_of(input logic [3:0]            op,
                                      input logic [ALU_DATA_W-1:0] a,
                                      input logic [ALU_DATA_W-1:0] b,
                                      input logic [ALU_DATA_W-1:0] res);
        case (op)
            ADD:     return res < a;
            SUB:     return a < b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl_if
// Request channel into the ALU sequencer.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1. The requester holds req_op/req_wide/req_load/
// req_operand stable and req_valid high until that edge; req_ready does not
// depend on req_valid.
//   req_valid    requester -> controller  request present
//   req_ready    controller -> requester  controller can accept
//   req_op       requester -> controller  ALU opcode (alu_op_e)
//   req_wide     requester -> controller  1 = 16-bit op, 0 = 8-bit op
//   req_load     requester -> controller  load acc from req_operand
//   req_operand  requester -> controller  second operand / load value
// -----------------------------------------------------------------------------
interface alu_seq_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic        req_load;
    logic [15:0] req_operand;

    modport master (
        output req_valid, req_op, req_wide, req_load, req_operand,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_wide, req_load, req_operand,
        output req_ready
    );

endinterface

// File: rtl/alu_8.sv
// -----------------------------------------------------------------------------
// alu_8
// Combinational 8-bit ALU driven by alu_seq_ctrl.
//   a, b    in  8  operands
//   opcode  in  4  alu_op_e; undefined codes return ~a
//   out     out 8  result
// -----------------------------------------------------------------------------
module alu_8
    import alu_pkg::*;
(
    input  logic [ALU_DATA_W-1:0] a,
    input  logic [ALU_DATA_W-1:0] b,
    input  logic [3:0]            opcode,
    output logic [ALU_DATA_W-1:0] out
);

    always_comb begin
        out = '0;
        case (opcode)
            ADD:     out = a + b;
            SUB:     out = a - b;
            AND:     out = a & b;
            OR:      out = a | b;
            XOR:     out = a ^ b;
            default: out = ~a;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Sequences 8-bit and 16-bit accumulator operations over a combinational
// alu_8. A 16-bit op is a low pass, a high pass and, for ADD/SUB with a low
// carry, a CARRY pass that adds/subtracts 1 into the high byte.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req           alu_seq_ctrl_if.slave request channel
//   alu_a/alu_b   operands to alu_8, alu_opcode opcode to alu_8
//   alu_out       alu_8 result, captured in the cycle it is driven
//   acc           16-bit accumulator, flag_z/flag_c result flags
//   done          one-cycle pulse when a request retires
//   op_err        illegal opcode pulse (ALU_SEQ_ILLEGAL_OP_EN only)
//   state         current sequencer state (debug)
// Build option: define ALU_SEQ_ILLEGAL_OP_EN to reject opcodes 5..15 with
// op_err; otherwise they pass straight to alu_8 as an 8-bit op with C=0.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int OP_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_seq_ctrl_if.slave         req,
    output logic [ALU_DATA_W-1:0] alu_a,
    output logic [ALU_DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]       alu_opcode,
    input  logic [ALU_DATA_W-1:0] alu_out,
    output logic [ACC_W-1:0]      acc,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  done,
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    output logic                  op_err,
`endif
    output seq_state_e            state
);

    if (ACC_W != 2 * ALU_DATA_W) begin : g_acc_w_check
        $error("alu_seq_ctrl: ACC_W must be 2*ALU_DATA_W (16)");
    end
    if (OP_W != 4) begin : g_op_w_check
        $error("alu_seq_ctrl: OP_W must be 4");
    end

    seq_state_e            state_q, state_d;
    logic [OP_W-1:0]       op_q;
    logic [ACC_W-1:0]      opnd_q, acc_q;
    logic                  wide_q, load_q, nopass_q, issue_q, carry_q;
    logic                  z_q, c_q, done_q;
    logic                  accept, nopass_in, carry_now, retire, zero16;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    logic                  illegal_q, err_q;
`endif

    // issue_q marks the cycle between accepting an ALU request and its LO
    // pass; the controller is not ready during it.
    assign req.req_ready = (state_q == IDLE) && !issue_q;
    assign accept        = req.req_valid && req.req_ready;

    // Requests that never drive alu_8: loads, and rejected opcodes.
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    assign nopass_in = req.req_load || !is_legal_op(req.req_op);
`else
    assign nopass_in = req.req_load;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_q || (accept && nopass_in)) state_d = LO;
            LO:      state_d = (wide_q && !nopass_q) ? HI : IDLE;
            HI:      state_d = (is_add_sub(op_q) && carry_q) ? CARRY : IDLE;
            CARRY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        case (state_q)
            LO: if (!nopass_q) begin
                alu_a      = acc_q[ALU_DATA_W-1:0];
                alu_b      = opnd_q[ALU_DATA_W-1:0];
                alu_opcode = op_q;
            end
            HI: begin
                alu_a      = acc_q[ACC_W-1:ALU_DATA_W];
                alu_b      = opnd_q[ACC_W-1:ALU_DATA_W];
                alu_opcode = op_q;
            end
            CARRY: begin
                // acc high byte already holds the HI pass result here.
                alu_a      = acc_q[ACC_W-1:ALU_DATA_W];
                alu_b      = 8'h01;
                alu_opcode = op_q;
            end
            default: ;
        endcase
    end

    assign carry_now = carry_of(op_q, alu_a, alu_b, alu_out);
    assign retire    = (state_q != IDLE) && (state_d == IDLE);
    assign zero16    = ({alu_out, acc_q[ALU_DATA_W-1:0]} == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            wide_q   <= 1'b0;
            load_q   <= 1'b0;
            nopass_q <= 1'b0;
            issue_q  <= 1'b0;
            carry_q  <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= retire;
            issue_q <= accept && !nopass_in;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
            err_q   <= retire && illegal_q;
`endif
            if (accept) begin
                op_q     <= req.req_op;
                opnd_q   <= req.req_operand;
                load_q   <= req.req_load;
                nopass_q <= nopass_in;
                // Undefined opcodes always run as a single 8-bit pass.
                wide_q   <= req.req_wide && (req.req_load || is_legal_op(req.req_op));
`ifdef ALU_SEQ_ILLEGAL_OP_EN
                illegal_q <= !req.req_load && !is_legal_op(req.req_op);
`endif
            end
            case (state_q)
                LO: begin
                    if (load_q) begin
                        acc_q <= wide_q ? opnd_q
                                        : {acc_q[ACC_W-1:ALU_DATA_W], opnd_q[ALU_DATA_W-1:0]};
                    end else if (!nopass_q) begin
                        acc_q[ALU_DATA_W-1:0] <= alu_out;
                        carry_q               <= carry_now;
                        if (!wide_q) begin
                            z_q <= (alu_out == '0);
                            c_q <= carry_now;
                        end
                    end
                end
                HI: begin
                    acc_q[ACC_W-1:ALU_DATA_W] <= alu_out;
                    carry_q                   <= carry_now;
                    if (state_d == IDLE) begin
                        z_q <= zero16;
                        c_q <= carry_now;
                    end
                end
                CARRY: begin
                    acc_q[ACC_W-1:ALU_DATA_W] <= alu_out;
                    z_q <= zero16;
                    c_q <= carry_q | carry_now;
                end
                default: ;
            endcase
        end
    end

    assign acc    = acc_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign done   = done_q;
    assign state  = state_q;
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    assign op_err = err_q;
`endif

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller for the combinational alu_8 datapath, on the opposite side of the alu_8 a/b/opcode/out interface. It accepts ALU instruction requests over a valid/ready handshake and owns a 16-bit accumulator plus Z/C flags. It drives alu_8 operands and opcode, and captures alu_8 results. 16-bit operations are built from chained 8-bit passes with carry/borrow propagation.

Parameters:
ACC_W, 16, accumulator width; fixed at 2×8, any other value is a synthesis-time error
OP_W, 4, opcode width matching alu_8

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  4  ALU opcode (alu_op_e)
req_wide  in  1  1 = 16-bit operation, 0 = 8-bit operation on acc[7:0]
req_load  in  1  load acc from req_operand; no ALU pass
req_operand  in  16  second operand or load value (8-bit ops use [7:0])
alu_a  out  8  to alu_8 a
alu_b  out  8  to alu_8 b
alu_opcode  out  4  to alu_8 opcode
alu_out  in  8  from alu_8 out; combinational, sampled in the same cycle it is driven
acc  out  16  accumulator
flag_z  out  1  result zero
flag_c  out  1  carry/borrow
done  out  1  one-cycle pulse when an accepted request retires

Behaviour:
- Reset: state IDLE; acc=0, flag_z=0, flag_c=0, done=0; alu_a/alu_b/alu_opcode=0; req_ready=1 from the first cycle after reset.
- Accept condition: req_valid && req_ready at a clock edge (t0). Operand, op, wide and load are registered on that edge. req_ready=1 only in IDLE.
- State machine: IDLE -> LO -> (HI -> (CARRY)) -> IDLE.
- ALU drive by state (combinational from state and registered fields; all 0 in IDLE):
  - LO: a=acc[7:0], b=opnd[7:0], opcode=op.
  - HI: a=acc[15:8], b=opnd[15:8], opcode=op.
  - CARRY: a=high result, b=8'h01, opcode=op (ADD or SUB only).
- Carry/borrow: ADD c = (alu_out < alu_a); SUB c = (alu_a < alu_b); AND/OR/XOR c=0.
- 8-bit op: LO captures alu_out into acc[7:0]; acc[15:8] unchanged; flag_z=(alu_out==0), flag_c per rule. Returns to IDLE. done=1 and req_ready=1 at t0+2.
- 16-bit op:
  - LO captures the low byte and an internal carry ci.
  - HI captures the high byte and c_hi.
  - If op is ADD/SUB and ci=1, go to CARRY: the result replaces the high byte. Final C = c_hi | (ADD: out==0 ; SUB: a==0).
  - Otherwise final C = c_hi. flag_z = (16-bit result==0).
  - done at t0+3 without CARRY, t0+4 with CARRY.
- Load: no ALU pass. acc <= req_wide ? req_operand : {acc[15:8], req_operand[7:0]}. Flags unchanged. done at t0+1 via a one-cycle pass through LO with ALU outputs held 0.
- done is a registered pulse, high exactly one cycle, coincident with the return to IDLE. A back-to-back request may be accepted on that same edge.
- req_valid while busy: ignored (not accepted, no stall of internal state). The requester must hold the request until it sees req_ready.
- rst mid-operation: the operation is abandoned. Next cycle is IDLE with all reset values; no done pulse.
- req_load && req_op simultaneously: load wins; req_op is ignored.

Optional Feature:
ALU_SEQ_ILLEGAL_OP_EN
- Defined: adds output op_err (1 bit, reset 0).
  - req_op values 5..15 are rejected: no ALU pass, acc and flags unchanged.
  - done and op_err pulse together at t0+1.
- Undefined: op values 5..15 are passed through to alu_8 unchanged as a single 8-bit pass (req_wide ignored) with C=0.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e: ADD=4'h0, SUB=4'h1, AND=4'h2, OR=4'h3, XOR=4'h4.
  - seq_state_e: IDLE, LO, HI, CARRY.
  - ALU_DATA_W=8.
- No sub-module. Carry detection is small inline logic.
- The bench instantiates alu_seq_ctrl with a real alu_8 connected on the alu_* ports.

Test Plan:
- Load 16'h0007 (req_wide=1), then 8-bit ADD 8'h07 -> acc=16'h000E, Z=0, C=0, done at t0+2.
- Load 16'h000D, then 8-bit AND 8'h07 -> acc=16'h0005. Then SUB 8'h05 -> acc=16'h0000, Z=1, C=0.
- Load 16'h12F0, then wide ADD 16'h0120 -> passes LO/HI/CARRY, acc=16'h1410, C=0, done at t0+4. Load 16'hFFFF, then wide ADD 16'h0001 -> acc=16'h0000, Z=1, C=1.
- Load 16'h0100, then wide SUB 16'h0001 -> acc=16'h00FF, C=0. Wide XOR 16'hFFFF on 16'h00FF -> acc=16'hFF00, done at t0+3.
- Start wide ADD, assert rst during HI -> next cycle acc=0, flags 0, req_ready=1, no done. Back-to-back requests held valid -> second accepted on the done edge.
- op 4'hF with 8-bit operand: macro defined -> op_err=1, acc unchanged, done at t0+1; macro undefined -> alu_opcode=4'hF for one pass, acc[7:0]=alu_out, C=0.
